// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC scan controller.
package a2d_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {IDLE, CMD, READ, STORE} a2d_state_t;

  // old + ((new - old) >>> shift); the 13-bit signed difference keeps the sign of a falling input.
  function automatic logic [SAMPLE_W-1:0] iir_step(input logic [SAMPLE_W-1:0] old_s,
                                                   input logic [SAMPLE_W-1:0] new_s,
                                                   input int unsigned         shift);
    logic signed [SAMPLE_W:0] diff;
    logic signed [SAMPLE_W:0] step;
    diff = $signed({1'b0, new_s}) - $signed({1'b0, old_s});
    step = diff >>> shift;
    return old_s + step[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/SPI_mstr.sv
// SPI mode-0 master: one 16-bit full-duplex transfer per wrt pulse, SCLK = clk/4.
// MISO is sampled as SCLK rises, MOSI shifts as SCLK falls; done pulses as SS_n returns high.
module SPI_mstr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  logic        active_q;
  logic [1:0]  div_q;
  logic [3:0]  bit_q;
  logic [15:0] tx_q;
  logic [15:0] rx_q;
  logic        ss_n_q;
  logic        sclk_q;
  logic        done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      ss_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (wrt) begin
          active_q <= 1'b1;
          ss_n_q   <= 1'b0;
          tx_q     <= cmd;
          div_q    <= '0;
          bit_q    <= '0;
        end
      end else begin
        div_q <= div_q + 2'd1;
        if (div_q == 2'd1) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[14:0], MISO};
        end
        if (div_q == 2'd3) begin
          sclk_q <= 1'b0;
          tx_q   <= {tx_q[14:0], 1'b0};
          bit_q  <= bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            active_q <= 1'b0;
            ss_n_q   <= 1'b1;
            done_q   <= 1'b1;
          end
        end
      end
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = tx_q[15];
  assign done    = done_q;
  assign rd_data = rx_q;

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Round-robin ADC scanner: each slot costs two SPI frames (command, then read-back) and one store cycle.
// Launches are paced by a free-running interval counter; continuous via en or one sweep via start.
module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter logic [23:0] CH_MAP     = {12'h000, 3'd4, 3'd3, 3'd1, 3'd0},
  parameter int          INTERVAL_W = 14,
  parameter int          AVG_SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       start,
  input  logic                       MISO,
  output logic                       SS_n,
  output logic                       SCLK,
  output logic                       MOSI,
  output logic [SAMPLE_W*NUM_CH-1:0] data,
  output logic [NUM_CH-1:0]          valid,
  output logic                       sweep_done,
  output logic                       busy
);

  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  a2d_state_t                 state_q, state_d;
  logic [INTERVAL_W-1:0]      cnt_q;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic                       sweep_pend_q, sweep_pend_d;
  logic [SAMPLE_W*NUM_CH-1:0] data_q, data_d;
  logic [NUM_CH-1:0]          valid_q, valid_d;

  logic                wrt;
  logic                spi_done;
  logic [15:0]         cmd;
  logic [15:0]         rd_data;
  logic                launch;
  logic                last_slot;
  logic [2:0]          ch_sel;
  logic [SAMPLE_W-1:0] old_sample;
  logic                old_valid;
  logic [SAMPLE_W-1:0] new_sample;
  logic                unused_rd;

  assign launch    = &cnt_q;
  assign last_slot = (slot_q == SLOT_W'(NUM_CH - 1));
  assign cmd       = {2'b00, ch_sel, 11'h000};
  assign unused_rd = ^rd_data[15:SAMPLE_W];

  always_comb begin
    ch_sel     = '0;
    old_sample = '0;
    old_valid  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        ch_sel     = CH_MAP[3*i +: 3];
        old_sample = data_q[SAMPLE_W*i +: SAMPLE_W];
        old_valid  = valid_q[i];
      end
    end
  end

  // First sample of a slot seeds the filter instead of being averaged against zero.
  assign new_sample = (AVG_SHIFT == 0 || !old_valid) ? rd_data[SAMPLE_W-1:0]
                    : iir_step(old_sample, rd_data[SAMPLE_W-1:0], AVG_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch && (en || sweep_pend_q)) state_d = CMD;
      CMD:     if (spi_done) state_d = READ;
      READ:    if (spi_done) state_d = STORE;
      STORE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrt        = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      IDLE:    wrt = launch && (en || sweep_pend_q);
      CMD:     wrt = spi_done;
      STORE:   sweep_done = last_slot;
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

  // A start coinciding with the final store keeps the request pending for the next sweep.
  always_comb begin
    slot_d       = slot_q;
    data_d       = data_q;
    valid_d      = valid_q;
    sweep_pend_d = start ? 1'b1 : (sweep_done ? 1'b0 : sweep_pend_q);
    if (state_q == STORE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (slot_q == SLOT_W'(i)) begin
          data_d[SAMPLE_W*i +: SAMPLE_W] = new_sample;
          valid_d[i]                     = 1'b1;
        end
      end
      slot_d = last_slot ? '0 : slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      slot_q       <= '0;
      sweep_pend_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= '0;
    end else begin
      cnt_q        <= cnt_q + INTERVAL_W'(1);
      slot_q       <= slot_d;
      sweep_pend_q <= sweep_pend_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

  SPI_mstr u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .done    (spi_done),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Bench for a2d_scan_ctrl: three instances (4-slot raw, 1-slot filtered, 1-slot fast interval).
module tb_a2d_scan_ctrl;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] en;
  logic [2:0] start;
  wire  [2:0] miso;
  wire  [2:0] ss_n;
  wire  [2:0] sclk;
  wire  [2:0] mosi;
  wire  [2:0] busy;
  wire  [2:0] sd;
  logic [47:0] data0;
  logic [3:0]  valid0;
  logic [11:0] data1, data2;
  logic        valid1, valid2;

  always #5 clk = ~clk;

  a2d_scan_ctrl #(.NUM_CH(4), .INTERVAL_W(8), .AVG_SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .start(start[0]), .MISO(miso[0]),
    .SS_n(ss_n[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .data(data0), .valid(valid0),
    .sweep_done(sd[0]), .busy(busy[0]));

  a2d_scan_ctrl #(.NUM_CH(1), .INTERVAL_W(8), .AVG_SHIFT(2)) u_avg (
    .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .start(start[1]), .MISO(miso[1]),
    .SS_n(ss_n[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .data(data1), .valid(valid1),
    .sweep_done(sd[1]), .busy(busy[1]));

  a2d_scan_ctrl #(.NUM_CH(1), .INTERVAL_W(4), .AVG_SHIFT(0)) u_one (
    .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .start(start[2]), .MISO(miso[2]),
    .SS_n(ss_n[2]), .SCLK(sclk[2]), .MOSI(mosi[2]), .data(data2), .valid(valid2),
    .sweep_done(sd[2]), .busy(busy[2]));

  // ADC models: shift out adc_word MSB first, changing MISO on SCLK falling edges.
  logic [15:0] adc_word [3];
  logic [15:0] cmd_log [$];

  for (genvar g = 0; g < 3; g++) begin : g_adc
    int          falls = 0;
    int          base  = 0;
    int          xfers = 0;
    logic [15:0] sh    = '0;
    always @(negedge ss_n[g]) begin
      base = falls;
      xfers++;
    end
    always @(negedge sclk[g]) falls++;
    always @(posedge sclk[g]) sh = {sh[14:0], mosi[g]};
    assign miso[g] = (falls - base < 16) ? adc_word[g][15 - (falls - base)] : 1'b0;
    if (g == 0) begin : g_log
      always @(posedge ss_n[g]) if (rst_n[0] === 1'b1 && xfers > 0) cmd_log.push_back(sh);
    end
  end

  int sd_cnt0 = 0;
  int sd_cnt2 = 0;
  int edges2  = 0;
  always @(negedge clk) begin
    if (sd[0] === 1'b1) sd_cnt0++;
    if (sd[2] === 1'b1) sd_cnt2++;
  end
  always @(posedge clk) if (rst_n[2] === 1'b1) edges2++;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          inst;
    int          slot;
    logic [11:0] val;
  } exp_t;
  exp_t exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_busy(input int g, input logic lvl, input int max_cyc);
    int n;
    n = 0;
    while (busy[g] !== lvl && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("busy%0d_reaches_%0b", g, lvl), busy[g], lvl);
  endtask

  task automatic expect_store(input int inst, input int slot, input logic [11:0] val);
    exp_t e;
    e.inst = inst;
    e.slot = slot;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [11:0] obs;
    logic        vb;
    check("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (e.inst)
        0:       begin obs = data0[12*e.slot +: 12]; vb = valid0[e.slot]; end
        1:       begin obs = data1; vb = valid1; end
        default: begin obs = data2; vb = valid2; end
      endcase
      check($sformatf("data_i%0d_s%0d", e.inst, e.slot), obs, e.val);
      check($sformatf("valid_i%0d_s%0d", e.inst, e.slot), vb, 1);
    end
  endtask

  task automatic wait_store(input int g);
    wait_busy(g, 1'b1, 600);
    wait_busy(g, 1'b0, 300);
    pop_check();
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  logic [15:0] exp_cmd [4];
  logic [11:0] v;
  logic [11:0] avg_in  [4];
  logic [11:0] avg_out [4];
  int          busy_hi;
  int          n;
  int          last_fall;
  logic        saw_sd;

  initial begin
    exp_cmd = '{16'h0000, 16'h0800, 16'h1800, 16'h2000};
    avg_in  = '{12'h400, 12'h800, 12'h800, 12'h100};
    avg_out = '{12'h400, 12'h500, 12'h5C0, 12'h490};
    adc_word = '{16'h0000, 16'h0000, 16'h0000};
    en    = '0;
    start = '0;
    rst_n = 3'b111;
    #2 rst_n = 3'b000;
    repeat (3) @(negedge clk);

    check("rst_data0", data0, 0);
    check("rst_valid0", valid0, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sd, 0);
    check("rst_ss_n", ss_n, 3'b111);
    check("rst_sclk", sclk, 0);
    rst_n = 3'b111;

    // Single sweep on start with en low; a second start mid-sweep adds nothing.
    pulse_start(0);
    for (int s = 0; s < 4; s++) begin
      v = 12'h100 + 12'h111 * 12'(s);
      adc_word[0] = {4'hC, v};
      expect_store(0, s, v);
      wait_store(0);
      if (s == 1) pulse_start(0);
    end
    check("sweep1_data", data0, {12'h433, 12'h322, 12'h211, 12'h100});
    check("sweep1_valid", valid0, 4'hF);
    check("sweep1_sd_count", sd_cnt0, 1);
    check("cmd_count", cmd_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("cmd_%0d", i), (i < cmd_log.size()) ? cmd_log[i] : 16'hxxxx, exp_cmd[i/2]);
    busy_hi = 0;
    repeat (512) begin
      @(negedge clk);
      if (busy[0] === 1'b1) busy_hi++;
    end
    check("idle_after_sweep", busy_hi, 0);
    check("xfers_single_sweep", g_adc[0].xfers, 8);

    // Continuous scan.
    adc_word[0] = 16'h0A5A;
    en[0] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      expect_store(0, s, 12'hA5A);
      wait_store(0);
    end
    check("cont_data", data0, {4{12'hA5A}});
    check("cont_valid", valid0, 4'hF);
    check("cont_sd_count", sd_cnt0, 2);

    // Dropping en mid-conversion still finishes that slot.
    wait_busy(0, 1'b1, 600);
    en[0] = 1'b0;
    adc_word[0] = 16'hF5A5;
    expect_store(0, 0, 12'h5A5);
    wait_store(0);
    busy_hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy[0] === 1'b1) busy_hi++;
    end
    check("idle_after_en_drop", busy_hi, 0);
    check("held_slots_1_3", data0[47:12], {3{12'hA5A}});

    // Reset during the read frame of slot 1.
    adc_word[0] = 16'h0777;
    en[0] = 1'b1;
    wait_busy(0, 1'b1, 600);
    n = 0;
    while (ss_n[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("pre_rst_in_read", {busy[0], ss_n[0]}, 2'b10);
    #2 rst_n[0] = 1'b0;
    #1;
    check("midrst_ss_n", ss_n[0], 1);
    check("midrst_data", data0, 0);
    check("midrst_valid", valid0, 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_sd", sd[0], 0);
    @(negedge clk);
    cmd_log.delete();
    rst_n[0] = 1'b1;
    expect_store(0, 0, 12'h777);
    wait_store(0);
    en[0] = 1'b0;
    check("restart_cmd", (cmd_log.size() > 0) ? cmd_log[0] : 16'hxxxx, 16'h0000);
    check("restart_valid", valid0, 4'b0001);

    // Filtered instance.
    for (int k = 0; k < 4; k++) begin
      adc_word[1] = {4'hF, avg_in[k]};
      expect_store(1, 0, avg_out[k]);
      pulse_start(1);
      wait_store(1);
    end

    // Fast interval: each launch lands on the first counter wrap after going idle.
    en[2] = 1'b1;
    last_fall = 0;
    for (int k = 0; k < 5; k++) begin
      v = 12'h0A0 + 12'(k);
      adc_word[2] = {4'h3, v};
      expect_store(2, 0, v);
      wait_busy(2, 1'b1, 40);
      if (k == 0) check("one_launch_phase", edges2 % 16, 0);
      else check($sformatf("one_launch_edge_%0d", k), edges2, last_fall + 16 - (last_fall % 16));
      saw_sd = 1'b0;
      n = 0;
      while (busy[2] === 1'b1 && n < 300) begin
        if (sd[2] === 1'b1) saw_sd = 1'b1;
        @(negedge clk);
        n++;
      end
      check("one_busy_drop", busy[2], 0);
      check($sformatf("one_sd_store_%0d", k), saw_sd, 1);
      last_fall = edges2;
      pop_check();
    end
    en[2] = 1'b0;
    check("one_sd_count", sd_cnt2, 5);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/a2d_scan_ctrl.md
A2D_SCAN_CTRL -- requirements
Module: a2d_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of scanned channels (legal 1..8).
REQ-002 SHALL have parameter CH_MAP, default {3'd4,3'd3,3'd1,3'd0}, meaning packed 3-bit ADC channel per slot; slot i uses CH_MAP[3i+2:3i].
REQ-003 SHALL have parameter INTERVAL_W, default 14, meaning width of the inter-conversion delay counter.
REQ-004 SHALL have parameter AVG_SHIFT, default 0, meaning IIR filter shift (legal 0..3; 0 means no filtering).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  continuous scan enable.
REQ-008 SHALL have port start  input  1  single-cycle request for one full sweep of all slots.
REQ-009 SHALL have port MISO  input  1  SPI data from ADC.
REQ-010 SHALL have ports SS_n, SCLK, MOSI  output  1 each  SPI master signals.
REQ-011 SHALL have port data  output  12*NUM_CH  packed results; slot i in data[12i+11:12i].
REQ-012 SHALL have port valid  output  NUM_CH  slot i holds at least one conversion.
REQ-013 SHALL have port sweep_done  output  1  one-clk pulse when the last slot is stored.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL use states IDLE, CMD, READ, STORE.
REQ-016 SHALL run a free-running INTERVAL_W-bit counter; a launch is permitted only in the cycle the counter is all-ones.
REQ-017 SHALL, in IDLE with launch permitted and (en or sweep_pend), pulse wrt to the SPI master and go to CMD.
REQ-018 SHALL send cmd = {2'b00, CH_MAP slot, 11'h000} for the current slot index.
REQ-019 SHALL, in CMD on SPI done, pulse wrt again (same cmd) and go to READ; in READ on done go to STORE.
REQ-020 SHALL, in STORE (one cycle), update data for the current slot from rd_data[11:0], set valid[slot], advance the slot, return to IDLE.
REQ-021 SHALL wrap the slot index from NUM_CH-1 to 0 and pulse sweep_done in that STORE cycle.
REQ-022 SHALL, with AVG_SHIFT=0, store raw samples.
REQ-023 SHALL, with AVG_SHIFT>0, load the raw sample when valid[slot] is 0; otherwise store old + ((new-old) >>> AVG_SHIFT) using a 13-bit signed difference, truncated to 12 bits.
REQ-024 SHALL set sweep_pend on start and clear it on sweep_done; start while sweep_pend is set has no further effect.
REQ-025 SHALL, if start and sweep_done coincide, leave sweep_pend set (new sweep wins).
REQ-026 SHALL always complete an in-flight channel when en falls; the slot index is retained, not reset.
REQ-027 SHALL hold data and valid for slots not being stored.

Reset
REQ-028 SHALL, on rst_n low, clear state to IDLE, the counter, the slot index, sweep_pend, data, and valid to 0, and force sweep_done and busy to 0 immediately, including mid-transaction.
REQ-029 SHALL reset the SPI master with the same rst_n so SS_n returns high.

Structure
REQ-030 SHALL place the state enum and the 12-bit sample width constant in shared package a2d_pkg.
REQ-031 SHALL instantiate exactly one sub-module, SPI_mstr, for all SPI traffic.

Verification
REQ-032 SHALL cover default parameters with en=1 and ADC model returning 12'hA5A on every channel: after 4 STOREs data == {4{12'hA5A}}, valid == 4'hF, and one sweep_done pulse.
REQ-033 SHALL cover MOSI command checks: slot 2 transmits 16'h1800 and slot 3 transmits 16'h2000, each twice.
REQ-034 SHALL cover en=0 with a single start pulse: exactly 4 conversions occur, then busy stays low for 2 full counter periods.
REQ-035 SHALL cover AVG_SHIFT=2 with samples 12'h400 then 12'h800 on slot 0: stored values are 12'h400 then 12'h500.
REQ-036 SHALL cover rst_n asserted during READ: SS_n goes high and data/valid read 0 within the same cycle; after release the scan restarts at slot 0.
REQ-037 SHALL cover NUM_CH=1, INTERVAL_W=4 with en=1: a conversion is launched every time the counter wraps once idle, and sweep_done pulses on every STORE.
